// File: rtl/arm_pipe_pkg.sv
// rtl/arm_pipe_pkg.sv - shared pipeline constants, IF/ID entry type and flush counter helper
package arm_pipe_pkg;

  localparam int unsigned DEPTH       = 2;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned PTR_W       = 1;
  localparam int unsigned CNT_W       = 2;
  localparam int unsigned FLUSH_CNT_W = 8;
  localparam logic [DATA_W-1:0] PC_INC = 32'd4;

  typedef struct packed {
    logic [DATA_W-1:0] pc4;
    logic [DATA_W-1:0] instr;
  } if_id_entry_t;

  // Accumulate discarded entries without wrapping past all-ones.
  function automatic logic [FLUSH_CNT_W-1:0] flush_cnt_add(
    input logic [FLUSH_CNT_W-1:0] acc,
    input logic [CNT_W-1:0]       n
  );
    logic [FLUSH_CNT_W:0] sum;
    sum = {1'b0, acc} + {{(FLUSH_CNT_W+1-CNT_W){1'b0}}, n};
    return sum[FLUSH_CNT_W] ? {FLUSH_CNT_W{1'b1}} : sum[FLUSH_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/if_id_queue_mem.sv
// rtl/if_id_queue_mem.sv - two-entry pc4/instr storage with one write and one read port
module if_id_queue_mem
  import arm_pipe_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_ptr,
  input  if_id_entry_t     wr_data,
  input  logic [PTR_W-1:0] rd_ptr,
  output if_id_entry_t     rd_data
);

  if_id_entry_t mem [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Asynchronous read so a freshly written head is visible right after its edge.
  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - IF/ID two-entry instruction queue with flush, freeze and flush statistics
module if_id_queue
  import arm_pipe_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic [DATA_W-1:0]      in_pc,
  input  logic [DATA_W-1:0]      in_instr,
  output logic                   in_ready,
  input  logic                   flush,
  input  logic                   freeze,
  input  logic                   sram_ready,
  output logic                   out_valid,
  output logic [DATA_W-1:0]      out_pc4,
  output logic [DATA_W-1:0]      out_instr,
  output logic [CNT_W-1:0]       count,
  output logic [FLUSH_CNT_W-1:0] flush_cnt
);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             enq;
  logic             deq;
  logic [CNT_W-1:0] flush_n;
  if_id_entry_t     wr_data;
  if_id_entry_t     rd_data;

  // in_ready depends only on registered occupancy, so a dequeue cannot open a slot early.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign enq       = in_valid & in_ready & ~flush;
  assign deq       = out_valid & ~freeze & sram_ready & ~flush;
  assign flush_n   = count + {{(CNT_W-1){1'b0}}, in_valid & in_ready};

  assign wr_data.pc4   = in_pc + PC_INC;
  assign wr_data.instr = in_instr;

  assign out_pc4   = out_valid ? rd_data.pc4   : '0;
  assign out_instr = out_valid ? rd_data.instr : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      flush_cnt <= '0;
    end else if (flush) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      flush_cnt <= flush_cnt_add(flush_cnt, flush_n);
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  if_id_queue_mem u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (enq),
    .wr_ptr  (wr_ptr),
    .wr_data (wr_data),
    .rd_ptr  (rd_ptr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - directed self-checking bench for if_id_queue
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        flush;
  logic        freeze;
  logic        sram_ready;
  logic        out_valid;
  logic [31:0] out_pc4;
  logic [31:0] out_instr;
  logic [1:0]  count;
  logic [7:0]  flush_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  if_id_queue dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_pc      (in_pc),
    .in_instr   (in_instr),
    .in_ready   (in_ready),
    .flush      (flush),
    .freeze     (freeze),
    .sram_ready (sram_ready),
    .out_valid  (out_valid),
    .out_pc4    (out_pc4),
    .out_instr  (out_instr),
    .count      (count),
    .flush_cnt  (flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs and samples both sit 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] ins);
    in_valid = 1'b1;
    in_pc    = pc;
    in_instr = ins;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
    flush = 1'b0; freeze = 1'b0; sram_ready = 1'b0;
    tick(); tick();
    check("rst_count", {30'b0, count}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_pc4", out_pc4, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_flush_cnt", {24'b0, flush_cnt}, 32'd0);
    reset_n = 1'b1;

    // single enqueue, held by sram_ready=0
    fetch(32'h10, 32'hE3A01005);
    check("enq1_valid", {31'b0, out_valid}, 32'd1);
    check("enq1_pc4", out_pc4, 32'h14);
    check("enq1_instr", out_instr, 32'hE3A01005);
    check("enq1_count", {30'b0, count}, 32'd1);
    sram_ready = 1'b1;
    tick();
    check("deq1_count", {30'b0, count}, 32'd0);
    check("deq1_instr", out_instr, 32'h0);

    // freeze fills the queue, third fetch held
    freeze = 1'b1;
    fetch(32'h0, 32'hA0);
    fetch(32'h4, 32'hA4);
    check("full_count", {30'b0, count}, 32'd2);
    check("full_in_ready", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b1; in_pc = 32'h8; in_instr = 32'hA8;
    tick();
    check("held_count", {30'b0, count}, 32'd2);
    check("held_head", out_pc4, 32'h4);
    freeze = 1'b0;
    tick();
    check("drain1_pc4", out_pc4, 32'h8);
    check("drain1_count", {30'b0, count}, 32'd1);
    tick();
    check("drain2_pc4", out_pc4, 32'hC);
    check("drain2_count", {30'b0, count}, 32'd1);
    in_valid = 1'b0;
    tick();
    check("drain3_count", {30'b0, count}, 32'd0);

    // flush at full and at one entry
    freeze = 1'b1;
    fetch(32'h100, 32'hB0);
    fetch(32'h104, 32'hB4);
    in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush2_count", {30'b0, count}, 32'd0);
    check("flush2_instr", out_instr, 32'h0);
    check("flush2_cnt", {24'b0, flush_cnt}, 32'd2);
    fetch(32'h108, 32'hB8);
    in_valid = 1'b1; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("flush1_count", {30'b0, count}, 32'd0);
    check("flush1_cnt", {24'b0, flush_cnt}, 32'd4);

    // simultaneous enqueue/dequeue
    freeze = 1'b0; sram_ready = 1'b0;
    fetch(32'h200, 32'hC0);
    sram_ready = 1'b1;
    fetch(32'h300, 32'hC1);
    check("rw_count", {30'b0, count}, 32'd1);
    check("rw_head_pc4", out_pc4, 32'h304);
    check("rw_head_instr", out_instr, 32'hC1);
    sram_ready = 1'b0;
    fetch(32'h400, 32'hC2);
    check("stall_count", {30'b0, count}, 32'd2);
    check("stall_head", out_pc4, 32'h304);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush3_cnt", {24'b0, flush_cnt}, 32'd6);

    // PC wrap, then saturation
    fetch(32'hFFFFFFFC, 32'hD0);
    check("wrap_pc4", out_pc4, 32'h0);
    check("wrap_valid", {31'b0, out_valid}, 32'd1);
    freeze = 1'b1;
    for (int i = 0; i < 300; i++) begin
      while (count != 2'd2) fetch(32'h600, 32'hE0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end
    check("sat_cnt", {24'b0, flush_cnt}, 32'hFF);
    fetch(32'h700, 32'hE1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("sat_hold", {24'b0, flush_cnt}, 32'hFF);

    // mid-cycle async reset at full
    fetch(32'h800, 32'hF0);
    fetch(32'h804, 32'hF4);
    check("pre_rst_count", {30'b0, count}, 32'd2);
    in_valid = 1'b1; in_pc = 32'h900; in_instr = 32'hF8;
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_count", {30'b0, count}, 32'd0);
    check("arst_valid", {31'b0, out_valid}, 32'd0);
    check("arst_in_ready", {31'b0, in_ready}, 32'd1);
    check("arst_flush_cnt", {24'b0, flush_cnt}, 32'd0);
    tick();
    check("arst_held", {30'b0, count}, 32'd0);
    reset_n = 1'b1;
    in_pc = 32'h500; in_instr = 32'hF9;
    tick();
    in_valid = 1'b0;
    check("post_rst_count", {30'b0, count}, 32'd1);
    check("post_rst_pc4", out_pc4, 32'h504);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
